// File: rtl/noc_flit_pkg.sv
// -----------------------------------------------------------------------------
// noc_flit_pkg
//   Shared definitions for the NoC flit link: flit/destination typedefs at the
//   default link geometry, the beat-register state encoding, and the width
//   function for credit counters (a counter must hold 0..depth inclusive).
// -----------------------------------------------------------------------------
package noc_flit_pkg;

  localparam int FLIT_W_DEFAULT = 128;
  localparam int DEST_W_DEFAULT = 6;

  typedef logic [FLIT_W_DEFAULT-1:0] flit_t;
  typedef logic [DEST_W_DEFAULT-1:0] dest_t;

  // Beat register occupancy: empty, or holding a beat still being serialized.
  typedef enum logic {
    BEAT_IDLE = 1'b0,
    BEAT_BUSY = 1'b1
  } beat_state_e;

  // A counter that starts full at `depth` needs to represent depth+1 values.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axis_flit_credit_tx_if.sv
// -----------------------------------------------------------------------------
// axis_flit_credit_tx_if
//   Bundles the AXI-Stream beat input and the data/dest/is_tail/send/credit
//   flit link of the credit transmitter.
//   master : the transmitter (consumes AXIS beats, drives the flit link,
//            receives credits).
//   slave  : the environment (user core driving AXIS, router receiving flits
//            and returning credits).
// -----------------------------------------------------------------------------
interface axis_flit_credit_tx_if #(
  parameter int TDATA_WIDTH          = 128,
  parameter int TDEST_WIDTH          = 4,
  parameter int TID_WIDTH            = 2,
  parameter int SERIALIZATION_FACTOR = 1
);
  localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
  localparam int DEST_WIDTH = TDEST_WIDTH + TID_WIDTH;

  logic                   axis_tvalid;
  logic                   axis_tready;
  logic [TDATA_WIDTH-1:0] axis_tdata;
  logic                   axis_tlast;
  logic [TID_WIDTH-1:0]   axis_tid;
  logic [TDEST_WIDTH-1:0] axis_tdest;

  logic [FLIT_WIDTH-1:0]  data_out;
  logic [DEST_WIDTH-1:0]  dest_out;
  logic                   is_tail_out;
  logic                   send_out;
  logic                   credit_in;

  modport master (
    input  axis_tvalid, axis_tdata, axis_tlast, axis_tid, axis_tdest, credit_in,
    output axis_tready, data_out, dest_out, is_tail_out, send_out
  );

  modport slave (
    output axis_tvalid, axis_tdata, axis_tlast, axis_tid, axis_tdest, credit_in,
    input  axis_tready, data_out, dest_out, is_tail_out, send_out
  );
endinterface

// File: rtl/noc_credit_counter.sv
// -----------------------------------------------------------------------------
// noc_credit_counter
//   Tracks free slots in a downstream buffer of DEPTH entries. Starts full.
//   Ports:
//     clk_noc, rst_noc_sync : clock, synchronous active-high reset
//     consume               : one slot used this cycle (caller only asserts
//                             it while has_credit is high)
//     credit_return         : one slot freed this cycle
//     count                 : current credit count, 0..DEPTH
//     has_credit            : count != 0
//   A return while already full saturates at DEPTH.
// -----------------------------------------------------------------------------
module noc_credit_counter
  import noc_flit_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = credit_w(DEPTH)
) (
  input  logic          clk_noc,
  input  logic          rst_noc_sync,
  input  logic          consume,
  input  logic          credit_return,
  output logic [CW-1:0] count,
  output logic          has_credit
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] count_d;

  // NOTE: default assigned first so every path drives count_d and no latch is inferred.
  always_comb begin
    count_d = count;
    case ({consume, credit_return})
      2'b10:   count_d = count - 1'b1;
      2'b01:   if (count != FULL) count_d = count + 1'b1;
      default: count_d = count;  // idle, or consume and return cancel out
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) count <= FULL;
    else              count <= count_d;
  end

  assign has_credit = (count != '0);

endmodule

// File: rtl/axis_flit_credit_tx.sv
// -----------------------------------------------------------------------------
// axis_flit_credit_tx
//   Credit-based flit transmitter. Accepts AXIS beats, splits each into
//   SERIALIZATION_FACTOR flits (least-significant slice first) and launches
//   them on a registered flit link only while downstream credit is available.
//   Ports:
//     clk_noc      : NoC clock (single domain)
//     rst_noc_sync : synchronous active-high reset; drops any held beat and
//                    restores credits to FLIT_BUFFER_DEPTH
//     bus          : axis_flit_credit_tx_if.master (AXIS in, flit link out,
//                    credit_in)
//   Optional build macro AXIS_FLIT_TX_PROTOCOL_CHECK_EN adds protocol
//   assertions; the synthesized logic is the same with or without it.
// -----------------------------------------------------------------------------
module axis_flit_credit_tx
  import noc_flit_pkg::*;
#(
  parameter int TDATA_WIDTH          = 128,
  parameter int TDEST_WIDTH          = 4,
  parameter int TID_WIDTH            = 2,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int FLIT_BUFFER_DEPTH    = 4,
  parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
  parameter int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH
) (
  input logic                  clk_noc,
  input logic                  rst_noc_sync,
  axis_flit_credit_tx_if.master bus
);

  localparam int IDX_W = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam int CW    = credit_w(FLIT_BUFFER_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SERIALIZATION_FACTOR - 1);

  beat_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Held beat, viewed as SF flit slices so slice idx is a plain index.
  logic [SERIALIZATION_FACTOR-1:0][FLIT_WIDTH-1:0] beat_q;
  logic                  tlast_q;
  logic [DEST_WIDTH-1:0] dest_q;

  logic [CW-1:0] credits;
  logic          has_credit;
  logic          busy, last_flit, issue, tready, accept;

  logic [FLIT_WIDTH-1:0] data_q;
  logic [DEST_WIDTH-1:0] dest_out_q;
  logic                  send_q, tail_q;

  assign busy      = (state_q == BEAT_BUSY);
  assign last_flit = (idx_q == LAST_IDX);
  assign issue     = busy & has_credit;
  // Ready while empty, or while the final flit leaves so the next beat can
  // land in the same cycle; never depends on tvalid.
  assign tready    = !busy | (issue & last_flit);
  assign accept    = bus.axis_tvalid & tready;

  noc_credit_counter #(.DEPTH(FLIT_BUFFER_DEPTH)) u_credits (
    .clk_noc       (clk_noc),
    .rst_noc_sync  (rst_noc_sync),
    .consume       (issue),
    .credit_return (bus.credit_in),
    .count         (credits),
    .has_credit    (has_credit)
  );

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q <= BEAT_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      BEAT_IDLE: begin
        if (accept) begin
          state_d = BEAT_BUSY;
          idx_d   = '0;
        end
      end
      BEAT_BUSY: begin
        // Without credit nothing moves: idx and the held beat stay put.
        if (issue) begin
          if (last_flit) begin
            idx_d   = '0;
            state_d = accept ? BEAT_BUSY : BEAT_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  // NOTE: payload registers carry no reset; state_q says whether they are meaningful.
  always_ff @(posedge clk_noc) begin
    if (accept) begin
      beat_q  <= bus.axis_tdata;
      tlast_q <= bus.axis_tlast;
      dest_q  <= {bus.axis_tid, bus.axis_tdest};
    end
  end

  // Link outputs: send/tail are one-cycle pulses, data/dest hold between flits.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      send_q     <= 1'b0;
      tail_q     <= 1'b0;
      data_q     <= '0;
      dest_out_q <= '0;
    end else begin
      send_q <= issue;
      tail_q <= issue & tlast_q & last_flit;
      if (issue) begin
        data_q     <= beat_q[idx_q];
        dest_out_q <= dest_q;
      end
    end
  end

  assign bus.axis_tready = tready;
  assign bus.send_out    = send_q;
  assign bus.is_tail_out = tail_q;
  assign bus.data_out    = data_q;
  assign bus.dest_out    = dest_out_q;

`ifdef AXIS_FLIT_TX_PROTOCOL_CHECK_EN
  a_credit_overflow : assert property (@(posedge clk_noc) disable iff (rst_noc_sync)
    !(bus.credit_in && !issue && credits == CW'(FLIT_BUFFER_DEPTH)));

  a_axis_payload_stable : assert property (@(posedge clk_noc) disable iff (rst_noc_sync)
    (bus.axis_tvalid && !tready) |=>
      $stable({bus.axis_tdata, bus.axis_tlast, bus.axis_tid, bus.axis_tdest}));

  a_axis_tvalid_held : assert property (@(posedge clk_noc) disable iff (rst_noc_sync)
    (bus.axis_tvalid && !tready) |=> bus.axis_tvalid);

  a_send_needs_credit : assert property (@(posedge clk_noc) disable iff (rst_noc_sync)
    bus.send_out |-> ($past(credits) != '0));
`else
  // The count itself is only observed by the checks; keep it visibly consumed.
  logic unused_credits;
  assign unused_credits = ^credits;
`endif

endmodule

// File: tb/tb_axis_flit_credit_tx.sv
module tb_axis_flit_credit_tx;

  logic clk_noc = 1'b0;
  logic rst_a   = 1'b1;
  logic rst_b   = 1'b1;

  int checks   = 0;
  int failures = 0;

  always #5 clk_noc = ~clk_noc;

  axis_flit_credit_tx_if #(.TDATA_WIDTH(128), .TDEST_WIDTH(4), .TID_WIDTH(2),
                           .SERIALIZATION_FACTOR(1)) if_a ();
  axis_flit_credit_tx_if #(.TDATA_WIDTH(128), .TDEST_WIDTH(4), .TID_WIDTH(2),
                           .SERIALIZATION_FACTOR(4)) if_b ();

  axis_flit_credit_tx #(.SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(4)) dut_a (
    .clk_noc      (clk_noc),
    .rst_noc_sync (rst_a),
    .bus          (if_a.master)
  );

  axis_flit_credit_tx #(.SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(4)) dut_b (
    .clk_noc      (clk_noc),
    .rst_noc_sync (rst_b),
    .bus          (if_b.master)
  );

  task automatic tick();
    @(posedge clk_noc);
    #1;
  endtask

  function automatic logic [127:0] beat_data(input int i);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(i);
    return {4{w}};
  endfunction

  task automatic idle_inputs();
    if_a.axis_tvalid = 1'b0; if_a.axis_tdata = '0; if_a.axis_tlast = 1'b0;
    if_a.axis_tid    = '0;   if_a.axis_tdest = '0; if_a.credit_in  = 1'b0;
    if_b.axis_tvalid = 1'b0; if_b.axis_tdata = '0; if_b.axis_tlast = 1'b0;
    if_b.axis_tid    = '0;   if_b.axis_tdest = '0; if_b.credit_in  = 1'b0;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    repeat (3) tick();
    rst_a = 1'b0;
  endtask

  task automatic reset_b();
    rst_b = 1'b1;
    repeat (3) tick();
    rst_b = 1'b0;
  endtask

  task automatic drive_a(input logic [127:0] d, input logic last,
                         input logic [1:0] tid, input logic [3:0] tdest);
    if_a.axis_tvalid = 1'b1;
    if_a.axis_tdata  = d;
    if_a.axis_tlast  = last;
    if_a.axis_tid    = tid;
    if_a.axis_tdest  = tdest;
  endtask

  // Offers beats 0..n_beats-1 on DUT A for n_cycles with no credit returns,
  // honouring the handshake; reports beats accepted and send_out pulses.
  task automatic run_beats_a(input int n_beats, input int n_cycles,
                             output int accepted, output int pulses);
    logic hs;
    accepted = 0;
    pulses   = 0;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      if (accepted < n_beats) drive_a(beat_data(accepted), 1'b1, 2'd0, 4'd1);
      else                    if_a.axis_tvalid = 1'b0;
      hs = if_a.axis_tvalid && if_a.axis_tready;
      tick();
      if (hs) accepted++;
      if (if_a.send_out) pulses++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) tick();
    checks++; if (if_a.send_out !== 1'b0) begin failures++; $display("FAIL reset_send_a: got %b expected 0", if_a.send_out); end
    checks++; if (if_a.is_tail_out !== 1'b0) begin failures++; $display("FAIL reset_tail_a: got %b expected 0", if_a.is_tail_out); end
    checks++; if (if_a.data_out !== 128'd0) begin failures++; $display("FAIL reset_data_a: got %h expected 0", if_a.data_out); end
    checks++; if (if_a.dest_out !== 6'd0) begin failures++; $display("FAIL reset_dest_a: got %h expected 0", if_a.dest_out); end
    checks++; if (if_b.send_out !== 1'b0) begin failures++; $display("FAIL reset_send_b: got %b expected 0", if_b.send_out); end
    checks++; if (if_b.data_out !== 32'd0) begin failures++; $display("FAIL reset_data_b: got %h expected 0", if_b.data_out); end
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
    checks++; if (if_a.axis_tready !== 1'b1) begin failures++; $display("FAIL reset_tready_a: got %b expected 1", if_a.axis_tready); end
    checks++; if (if_b.axis_tready !== 1'b1) begin failures++; $display("FAIL reset_tready_b: got %b expected 1", if_b.axis_tready); end
  endtask

  task automatic test_single_beat();
    idle_inputs();
    reset_a();
    drive_a(128'hDEAD_BEEF, 1'b1, 2'd2, 4'd5);
    checks++; if (if_a.axis_tready !== 1'b1) begin failures++; $display("FAIL single_tready: got %b expected 1", if_a.axis_tready); end
    tick();                      // accepted at this edge
    if_a.axis_tvalid = 1'b0;
    checks++; if (if_a.send_out !== 1'b0) begin failures++; $display("FAIL single_early_send: got %b expected 0", if_a.send_out); end
    tick();                      // issued last cycle, visible now
    checks++; if (if_a.send_out !== 1'b1) begin failures++; $display("FAIL single_send: got %b expected 1", if_a.send_out); end
    checks++; if (if_a.data_out !== 128'hDEAD_BEEF) begin failures++; $display("FAIL single_data: got %h expected deadbeef", if_a.data_out); end
    checks++; if (if_a.dest_out !== 6'b10_0101) begin failures++; $display("FAIL single_dest: got %b expected 100101", if_a.dest_out); end
    checks++; if (if_a.is_tail_out !== 1'b1) begin failures++; $display("FAIL single_tail: got %b expected 1", if_a.is_tail_out); end
    tick();
    checks++; if (if_a.send_out !== 1'b0) begin failures++; $display("FAIL single_pulse_end: got %b expected 0", if_a.send_out); end
    checks++; if (if_a.is_tail_out !== 1'b0) begin failures++; $display("FAIL single_tail_end: got %b expected 0", if_a.is_tail_out); end
    checks++; if (if_a.data_out !== 128'hDEAD_BEEF) begin failures++; $display("FAIL single_data_hold: got %h expected deadbeef", if_a.data_out); end
  endtask

  task automatic test_credit_exhaustion();
    int  accepted, pulses, extra;
    logic hs;
    idle_inputs();
    reset_a();
    run_beats_a(6, 12, accepted, pulses);
    // 4 credits: beats 0..3 leave, beat 4 is held, beat 5 waits on the bus.
    checks++; if (pulses !== 4) begin failures++; $display("FAIL exhaust_pulses: got %0d expected 4", pulses); end
    checks++; if (accepted !== 5) begin failures++; $display("FAIL exhaust_accepted: got %0d expected 5", accepted); end
    checks++; if (if_a.axis_tready !== 1'b0) begin failures++; $display("FAIL exhaust_tready: got %b expected 0", if_a.axis_tready); end
    if_a.credit_in = 1'b1;
    tick();
    if_a.credit_in = 1'b0;
    checks++; if (if_a.send_out !== 1'b0) begin failures++; $display("FAIL credit_next_cycle: got %b expected 0", if_a.send_out); end
    hs = if_a.axis_tvalid && if_a.axis_tready;
    tick();
    if (hs) accepted++;
    if_a.axis_tvalid = 1'b0;
    checks++; if (if_a.send_out !== 1'b1) begin failures++; $display("FAIL credit_flit: got %b expected 1", if_a.send_out); end
    checks++; if (if_a.data_out !== beat_data(4)) begin failures++; $display("FAIL credit_flit_data: got %h expected %h", if_a.data_out, beat_data(4)); end
    extra = 0;
    repeat (6) begin
      tick();
      if (if_a.send_out) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL credit_extra_flits: got %0d expected 0", extra); end
    checks++; if (accepted !== 6) begin failures++; $display("FAIL credit_accepted: got %0d expected 6", accepted); end
  endtask

  task automatic test_credit_overflow();
    int accepted, pulses;
    idle_inputs();
    reset_a();
    if_a.credit_in = 1'b1;       // return while already full: must saturate
    tick();
    if_a.credit_in = 1'b0;
    checks++; if (dut_a.credits !== 3'd4) begin failures++; $display("FAIL overflow_count: got %0d expected 4", dut_a.credits); end
    run_beats_a(6, 12, accepted, pulses);
    checks++; if (pulses !== 4) begin failures++; $display("FAIL overflow_pulses: got %0d expected 4", pulses); end
  endtask

  task automatic test_stream_one_credit();
    int   n;
    logic hs;
    idle_inputs();
    reset_a();
    n = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      drive_a(beat_data(n), 1'b1, 2'd1, 4'd3);
      if_a.credit_in = (cyc >= 4);
      hs = if_a.axis_tvalid && if_a.axis_tready;
      tick();
      if (hs) n++;
      // Sample index cyc+1: beat cyc-1 is on the link; credits sit at 1 from index 4.
      if (cyc + 1 >= 5 && cyc + 1 <= 14) begin
        checks++; if (if_a.send_out !== 1'b1) begin failures++; $display("FAIL stream_send c%0d: got %b expected 1", cyc + 1, if_a.send_out); end
        checks++; if (dut_a.credits !== 3'd1) begin failures++; $display("FAIL stream_credits c%0d: got %0d expected 1", cyc + 1, dut_a.credits); end
        checks++; if (if_a.data_out !== beat_data(cyc - 1)) begin failures++; $display("FAIL stream_data c%0d: got %h expected %h", cyc + 1, if_a.data_out, beat_data(cyc - 1)); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_serialization();
    logic [31:0] exp_flit [4];
    exp_flit[0] = 32'h1111_1111; exp_flit[1] = 32'h2222_2222;
    exp_flit[2] = 32'h3333_3333; exp_flit[3] = 32'h4444_4444;
    idle_inputs();
    reset_b();
    if_b.axis_tvalid = 1'b1;
    if_b.axis_tdata  = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    if_b.axis_tlast  = 1'b1;
    if_b.axis_tid    = 2'd1;
    if_b.axis_tdest  = 4'd9;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if_b.axis_tvalid = 1'b0;
      if (c <= 3) begin
        checks++; if (if_b.axis_tready !== 1'b0) begin failures++; $display("FAIL ser_tready c%0d: got %b expected 0", c, if_b.axis_tready); end
      end
      if (c >= 2 && c <= 5) begin
        checks++; if (if_b.send_out !== 1'b1) begin failures++; $display("FAIL ser_send c%0d: got %b expected 1", c, if_b.send_out); end
        checks++; if (if_b.data_out !== exp_flit[c-2]) begin failures++; $display("FAIL ser_data c%0d: got %h expected %h", c, if_b.data_out, exp_flit[c-2]); end
        checks++; if (if_b.is_tail_out !== (c == 5)) begin failures++; $display("FAIL ser_tail c%0d: got %b expected %b", c, if_b.is_tail_out, (c == 5)); end
        checks++; if (if_b.dest_out !== 6'b01_1001) begin failures++; $display("FAIL ser_dest c%0d: got %b expected 011001", c, if_b.dest_out); end
      end
      if (c == 6) begin
        checks++; if (if_b.send_out !== 1'b0) begin failures++; $display("FAIL ser_after: got %b expected 0", if_b.send_out); end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [31:0] exp_flit [4];
    logic [31:0] got_flit [4];
    int sends;
    exp_flit[0] = 32'h5555_5555; exp_flit[1] = 32'h6666_6666;
    exp_flit[2] = 32'h7777_7777; exp_flit[3] = 32'h8888_8888;
    idle_inputs();
    reset_b();
    if_b.axis_tvalid = 1'b1;
    if_b.axis_tdata  = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    if_b.axis_tlast  = 1'b1;
    tick();                      // c1: accepted
    if_b.axis_tvalid = 1'b0;
    tick();                      // c2: flit 0 out
    tick();                      // c3: flit 1 out
    checks++; if (if_b.send_out !== 1'b1 || if_b.data_out !== 32'hBBBB_BBBB) begin failures++; $display("FAIL mid_second_flit: got send=%b data=%h expected 1/bbbbbbbb", if_b.send_out, if_b.data_out); end
    rst_b = 1'b1;
    tick();
    checks++; if (if_b.send_out !== 1'b0) begin failures++; $display("FAIL mid_rst_send1: got %b expected 0", if_b.send_out); end
    tick();
    checks++; if (if_b.send_out !== 1'b0) begin failures++; $display("FAIL mid_rst_send2: got %b expected 0", if_b.send_out); end
    rst_b = 1'b0;
    tick();
    checks++; if (if_b.send_out !== 1'b0) begin failures++; $display("FAIL mid_post_send: got %b expected 0", if_b.send_out); end
    checks++; if (if_b.axis_tready !== 1'b1) begin failures++; $display("FAIL mid_post_tready: got %b expected 1", if_b.axis_tready); end
    if_b.axis_tvalid = 1'b1;
    if_b.axis_tdata  = 128'h8888_8888_7777_7777_6666_6666_5555_5555;
    sends = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if_b.axis_tvalid = 1'b0;
      if (if_b.send_out) begin
        if (sends < 4) got_flit[sends] = if_b.data_out;
        sends++;
      end
    end
    checks++; if (sends !== 4) begin failures++; $display("FAIL mid_new_sends: got %0d expected 4", sends); end
    if (sends >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_flit[i] !== exp_flit[i]) begin failures++; $display("FAIL mid_new_flit%0d: got %h expected %h", i, got_flit[i], exp_flit[i]); end
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_beat();
    test_credit_exhaustion();
    test_credit_overflow();
    test_stream_one_credit();
    test_serialization();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
